// File: rtl/morus_tx_queue_if.sv
// Symbol handshake between the control block and the Morse transmit queue.
interface morus_tx_queue_if;
  logic       IN_VALID;
  logic       IN_READY;
  logic [2:0] SYM_LEN;
  logic [4:0] SYM_PAT;

  modport master (
    output IN_VALID,
    output SYM_LEN,
    output SYM_PAT,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID,
    input  SYM_LEN,
    input  SYM_PAT,
    output IN_READY
  );
endinterface

// File: rtl/morus_tx_queue.sv
// Morse transmitter with an input symbol FIFO. Pre-encoded characters are queued and keyed
// onto MORUS_OUT with 1/3/1/3/7 unit timing; MORUS_LED mirrors the keyed line.
module morus_tx_queue #(
  parameter int unsigned UNIT_CYC = 5000000,
  parameter int unsigned DEPTH    = 16,
  parameter bit          OUT_INV  = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  morus_tx_queue_if.slave        sym_if,
  input  logic                   ABORT,
  output logic                   MORUS_OUT,
  output logic                   MORUS_LED,
  output logic                   BUSY,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   ERR
);

  localparam int unsigned CycW = $clog2(UNIT_CYC);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StMark, StSpace, StCgap, StWgap} state_e;

  state_e          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [2:0]      unit_q, unit_d;
  logic [4:0]      pat_q, pat_d;
  logic [2:0]      idx_q, idx_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;
  logic            out_q, led_q, out_d;
  logic [7:0]      mem_q [DEPTH];

  logic       in_ready, push, pop, try_pop, unit_end, cur_dash;
  logic [2:0] head_len, mark_last;
  logic [4:0] head_pat;

  assign in_ready  = count_q < CntW'(DEPTH);
  assign push      = sym_if.IN_VALID && in_ready && !ABORT;
  assign head_len  = mem_q[rptr_q][7:5];
  assign head_pat  = mem_q[rptr_q][4:0];
  assign unit_end  = cyc_q == CycW'(UNIT_CYC - 1);
  assign cur_dash  = pat_q[idx_q];
  assign mark_last = cur_dash ? 3'd2 : 3'd0;

  // Keying FSM: unit timing, element sequencing and pop/decode of the FIFO head.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    pop     = 1'b0;
    try_pop = 1'b0;

    if (state_q != StIdle) begin
      cyc_d = unit_end ? '0 : cyc_q + CycW'(1);
    end

    case (state_q)
      StIdle: try_pop = 1'b1;
      StMark: begin
        if (unit_end) begin
          if (unit_q == mark_last) begin
            unit_d  = '0;
            state_d = (idx_q == 3'd0) ? StCgap : StSpace;
          end else begin
            unit_d = unit_q + 3'd1;
          end
        end
      end
      StSpace: begin
        if (unit_end) begin
          unit_d  = '0;
          idx_d   = idx_q - 3'd1;
          state_d = StMark;
        end
      end
      StCgap: begin
        if (unit_end) begin
          if (unit_q == 3'd2) begin
            unit_d  = '0;
            state_d = StIdle;
            try_pop = 1'b1;
          end else begin
            unit_d = unit_q + 3'd1;
          end
        end
      end
      StWgap: begin
        if (unit_end) begin
          if (unit_q == 3'd3) begin
            unit_d  = '0;
            state_d = StIdle;
            try_pop = 1'b1;
          end else begin
            unit_d = unit_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Shared decode so a gap can chain straight into the next symbol without an idle bubble.
    if (try_pop && count_q != '0) begin
      pop    = 1'b1;
      cyc_d  = '0;
      unit_d = '0;
      if (head_len == 3'd0) begin
        state_d = StWgap;
      end else if (head_len <= 3'd5) begin
        state_d = StMark;
        pat_d   = head_pat;
        idx_d   = head_len - 3'd1;
      end else begin
        state_d = StIdle;
        err_d   = 1'b1;
      end
    end

    if (ABORT) begin
      state_d = StIdle;
      cyc_d   = '0;
      unit_d  = '0;
      pop     = 1'b0;
      err_d   = 1'b0;
    end
  end

  // FIFO pointer and occupancy update; a full FIFO refuses pushes even when popping.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (ABORT) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Keyed level follows the next state so the mark starts on the edge that enters MARK.
  always_comb begin
    out_d = (state_d == StMark) ^ OUT_INV;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      unit_q  <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      out_q   <= OUT_INV;
      led_q   <= OUT_INV;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      out_q   <= out_d;
      led_q   <= out_d;
    end
  end

  // Symbol storage; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (RST && push) begin
      mem_q[wptr_q] <= {sym_if.SYM_LEN, sym_if.SYM_PAT};
    end
  end

  assign sym_if.IN_READY = in_ready;
  assign MORUS_OUT       = out_q;
  assign MORUS_LED       = led_q;
  assign BUSY            = state_q != StIdle;
  assign COUNT           = count_q;
  assign ERR             = err_q;

endmodule

// File: tb/tb_morus_tx_queue.sv
// Bench for morus_tx_queue: expected keying runs are queued as symbols are pushed and compared
// against runs recorded from MORUS_OUT while the transmitter is busy.
module tb_morus_tx_queue;
  localparam int unsigned U = 4;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic abort = 1'b0;
  logic morus_out, morus_led, busy, err;
  logic [$clog2(D):0] count;

  int vectors = 0;
  int miscompares = 0;

  int exp_lvl[$];
  int exp_len[$];
  int obs_lvl[$];
  int obs_len[$];
  bit mon_en = 1'b0;

  morus_tx_queue_if u_if ();

  morus_tx_queue #(
    .UNIT_CYC(U),
    .DEPTH   (D),
    .OUT_INV (1'b0)
  ) u_dut (
    .CLK      (clk),
    .RST      (rst),
    .sym_if   (u_if),
    .ABORT    (abort),
    .MORUS_OUT(morus_out),
    .MORUS_LED(morus_led),
    .BUSY     (busy),
    .COUNT    (count),
    .ERR      (err)
  );

  always #5 clk = ~clk;

  // Run-length recorder of the keyed line while BUSY, plus the LED copy check.
  initial begin
    int  cur_lvl;
    int  cur_len;
    bit  in_run;
    in_run = 1'b0;
    cur_lvl = 0;
    cur_len = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        vectors++;
        if (morus_led !== morus_out) begin
          miscompares++;
          $display("FAIL led_copy: got %b, want %b", morus_led, morus_out);
        end
        if (busy) begin
          if (in_run && int'(morus_out) == cur_lvl) begin
            cur_len++;
          end else begin
            if (in_run) begin
              obs_lvl.push_back(cur_lvl);
              obs_len.push_back(cur_len);
            end
            cur_lvl = int'(morus_out);
            cur_len = 1;
            in_run  = 1'b1;
          end
        end else if (in_run) begin
          obs_lvl.push_back(cur_lvl);
          obs_len.push_back(cur_len);
          in_run = 1'b0;
        end
      end
    end
  end

  // Expected keying for one symbol in unit multiples; a word space extends the preceding gap.
  task automatic model_sym(input logic [2:0] len, input logic [4:0] pat);
    int last;
    if (len == 3'd0) begin
      if (exp_lvl.size() > 0 && exp_lvl[exp_lvl.size()-1] == 0) begin
        last = exp_len.pop_back();
        exp_len.push_back(last + 4 * U);
      end else begin
        exp_lvl.push_back(0);
        exp_len.push_back(4 * U);
      end
    end else if (len <= 3'd5) begin
      for (int i = int'(len) - 1; i >= 0; i--) begin
        exp_lvl.push_back(1);
        exp_len.push_back(pat[i] ? 3 * U : U);
        if (i > 0) begin
          exp_lvl.push_back(0);
          exp_len.push_back(U);
        end
      end
      exp_lvl.push_back(0);
      exp_len.push_back(3 * U);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic push_sym(input logic [2:0] len, input logic [4:0] pat, input bit model);
    int w;
    u_if.SYM_LEN  = len;
    u_if.SYM_PAT  = pat;
    u_if.IN_VALID = 1'b1;
    w = 0;
    while (!u_if.IN_READY && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    u_if.IN_VALID = 1'b0;
    if (model) model_sym(len, pat);
  endtask

  task automatic wait_idle(output bit idle_ok);
    idle_ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle_ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    u_if.IN_VALID = 1'b1;
    u_if.SYM_LEN  = 3'd1;
    u_if.SYM_PAT  = 5'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if (morus_out !== 1'b0 || morus_led !== 1'b0 || count !== '0 || u_if.IN_READY !== 1'b1
        || busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got out=%b led=%b count=%0d ready=%b busy=%b err=%b, want 0 0 0 1 0 0",
               morus_out, morus_led, count, u_if.IN_READY, busy, err);
    end
    u_if.IN_VALID = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    vectors++;
    if (count !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_beats_push: got count=%0d busy=%b, want 0 0", count, busy);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    bit idle_ok;
    int el, en, ol, on;
    push_sym(3'd2, 5'b00001, 1'b1);
    vectors++;
    if (morus_out !== 1'b0 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL single_queued: got out=%b count=%0d, want 0 1", morus_out, count);
    end
    @(negedge clk);
    vectors++;
    if (morus_out !== 1'b1 || busy !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL single_latency: got out=%b busy=%b count=%0d, want 1 1 0",
               morus_out, busy, count);
    end
    wait_idle(idle_ok);
    vectors++;
    if (!idle_ok) begin
      miscompares++;
      $display("FAIL single_idle: got busy=%b, want 0", busy);
    end
    vectors++;
    if (obs_lvl.size() != exp_lvl.size()) begin
      miscompares++;
      $display("FAIL single_runs: got %0d runs, want %0d", obs_lvl.size(), exp_lvl.size());
    end
    while (exp_lvl.size() > 0) begin
      el = exp_lvl.pop_front();
      en = exp_len.pop_front();
      if (obs_lvl.size() > 0) begin
        ol = obs_lvl.pop_front();
        on = obs_len.pop_front();
      end else begin
        ol = -1;
        on = 0;
      end
      vectors++;
      if (ol != el || on != en) begin
        miscompares++;
        $display("FAIL single_run: got lvl %0d x%0d, want lvl %0d x%0d", ol, on, el, en);
      end
    end
    obs_lvl.delete();
    obs_len.delete();
  endtask

  task automatic test_back_to_back();
    bit idle_ok;
    int el, en, ol, on;
    push_sym(3'd1, 5'b00000, 1'b1);
    push_sym(3'd1, 5'b00001, 1'b1);
    wait_idle(idle_ok);
    vectors++;
    if (!idle_ok) begin
      miscompares++;
      $display("FAIL b2b_idle: got busy=%b, want 0", busy);
    end
    vectors++;
    if (obs_lvl.size() != exp_lvl.size()) begin
      miscompares++;
      $display("FAIL b2b_runs: got %0d runs, want %0d", obs_lvl.size(), exp_lvl.size());
    end
    while (exp_lvl.size() > 0) begin
      el = exp_lvl.pop_front();
      en = exp_len.pop_front();
      if (obs_lvl.size() > 0) begin
        ol = obs_lvl.pop_front();
        on = obs_len.pop_front();
      end else begin
        ol = -1;
        on = 0;
      end
      vectors++;
      if (ol != el || on != en) begin
        miscompares++;
        $display("FAIL b2b_run: got lvl %0d x%0d, want lvl %0d x%0d", ol, on, el, en);
      end
    end
    obs_lvl.delete();
    obs_len.delete();
  endtask

  task automatic test_word_space();
    bit idle_ok;
    int el, en, ol, on;
    push_sym(3'd1, 5'b00000, 1'b1);
    push_sym(3'd0, 5'b00000, 1'b1);
    push_sym(3'd1, 5'b00000, 1'b1);
    wait_idle(idle_ok);
    vectors++;
    if (!idle_ok) begin
      miscompares++;
      $display("FAIL word_idle: got busy=%b, want 0", busy);
    end
    vectors++;
    if (obs_lvl.size() != exp_lvl.size()) begin
      miscompares++;
      $display("FAIL word_runs: got %0d runs, want %0d", obs_lvl.size(), exp_lvl.size());
    end
    while (exp_lvl.size() > 0) begin
      el = exp_lvl.pop_front();
      en = exp_len.pop_front();
      if (obs_lvl.size() > 0) begin
        ol = obs_lvl.pop_front();
        on = obs_len.pop_front();
      end else begin
        ol = -1;
        on = 0;
      end
      vectors++;
      if (ol != el || on != en) begin
        miscompares++;
        $display("FAIL word_run: got lvl %0d x%0d, want lvl %0d x%0d", ol, on, el, en);
      end
    end
    obs_lvl.delete();
    obs_len.delete();
  endtask

  task automatic test_full();
    bit idle_ok;
    int el, en, ol, on;
    push_sym(3'd1, 5'b00001, 1'b1);  // T
    push_sym(3'd1, 5'b00000, 1'b1);  // E
    push_sym(3'd1, 5'b00001, 1'b1);  // T
    push_sym(3'd2, 5'b00000, 1'b1);  // I
    push_sym(3'd2, 5'b00011, 1'b1);  // M
    vectors++;
    if (u_if.IN_READY !== 1'b0 || count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_flag: got ready=%b count=%0d, want 0 4", u_if.IN_READY, count);
    end
    push_sym(3'd2, 5'b00010, 1'b1);  // N, held until a slot frees
    vectors++;
    if (count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_refill: got count=%0d, want 4", count);
    end
    wait_idle(idle_ok);
    vectors++;
    if (!idle_ok) begin
      miscompares++;
      $display("FAIL full_idle: got busy=%b, want 0", busy);
    end
    vectors++;
    if (obs_lvl.size() != exp_lvl.size()) begin
      miscompares++;
      $display("FAIL full_runs: got %0d runs, want %0d", obs_lvl.size(), exp_lvl.size());
    end
    while (exp_lvl.size() > 0) begin
      el = exp_lvl.pop_front();
      en = exp_len.pop_front();
      if (obs_lvl.size() > 0) begin
        ol = obs_lvl.pop_front();
        on = obs_len.pop_front();
      end else begin
        ol = -1;
        on = 0;
      end
      vectors++;
      if (ol != el || on != en) begin
        miscompares++;
        $display("FAIL full_run: got lvl %0d x%0d, want lvl %0d x%0d", ol, on, el, en);
      end
    end
    obs_lvl.delete();
    obs_len.delete();
  endtask

  task automatic test_error();
    push_sym(3'd7, 5'b10101, 1'b1);
    vectors++;
    if (err !== 1'b0 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL err_before: got err=%b count=%0d, want 0 1", err, count);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b1 || count !== 3'd0 || busy !== 1'b0 || morus_out !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse: got err=%b count=%0d busy=%b out=%b, want 1 0 0 0",
               err, count, busy, morus_out);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_width: got err=%b, want 0", err);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_lvl.size() != 0 || exp_lvl.size() != 0) begin
      miscompares++;
      $display("FAIL err_no_mark: got %0d runs, want 0", obs_lvl.size());
    end
  endtask

  task automatic test_abort();
    push_sym(3'd1, 5'b00001, 1'b0);
    push_sym(3'd1, 5'b00000, 1'b0);
    push_sym(3'd1, 5'b00000, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (morus_out !== 1'b1 || count !== 3'd2) begin
      miscompares++;
      $display("FAIL abort_setup: got out=%b count=%0d, want 1 2", morus_out, count);
    end
    abort         = 1'b1;
    u_if.IN_VALID = 1'b1;
    u_if.SYM_LEN  = 3'd1;
    u_if.SYM_PAT  = 5'd0;
    @(negedge clk);
    abort         = 1'b0;
    u_if.IN_VALID = 1'b0;
    vectors++;
    if (morus_out !== 1'b0 || morus_led !== 1'b0 || count !== 3'd0 || busy !== 1'b0
        || u_if.IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_flush: got out=%b led=%b count=%0d busy=%b ready=%b, want 0 0 0 0 1",
               morus_out, morus_led, count, busy, u_if.IN_READY);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || morus_out !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL abort_quiet: got busy=%b out=%b count=%0d, want 0 0 0", busy, morus_out, count);
    end
    obs_lvl.delete();
    obs_len.delete();
  endtask

  initial begin
    u_if.IN_VALID = 1'b0;
    u_if.SYM_LEN  = 3'd0;
    u_if.SYM_PAT  = 5'd0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_word_space();
    test_full();
    test_error();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
